// File: rtl/lc3_pkg.sv
// lc3_pkg: opcodes, control-field encodings and the execute control struct for the LC-3 decode stage
package lc3_pkg;
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] PC1_OFF11 = 2'b00;
    localparam logic [1:0] PC1_OFF9  = 2'b01;
    localparam logic [1:0] PC1_OFF6  = 2'b10;
    localparam logic [1:0] PC1_ZERO  = 2'b11;

    localparam logic [1:0] W_ALU    = 2'b00;
    localparam logic [1:0] W_MEM    = 2'b01;
    localparam logic [1:0] W_PCADDR = 2'b10;

    typedef struct packed {
        logic [1:0] alu_control;
        logic [1:0] pcselect1;
        logic       pcselect2;
        logic       op2select;
    } e_ctrl_t;
endpackage

// File: rtl/decode_ctrl_lut.sv
// decode_ctrl_lut: combinational opcode/IR[5] to execute, writeback and memory control words
//   opcode   in  4  instruction bits [15:12]
//   ir5      in  1  instruction bit 5 (immediate flag for ADD/AND)
//   e_ctrl   out 6  {alu_control, pcselect1, pcselect2, op2select}
//   w_ctrl   out 2  writeback source select
//   m_ctrl   out 1  indirect memory access
//   illegal  out 1  opcode not supported by this pipeline
module decode_ctrl_lut
    import lc3_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       ir5,
    output e_ctrl_t    e_ctrl,
    output logic [1:0] w_ctrl,
    output logic       m_ctrl,
    output logic       illegal
);
    always_comb begin
        e_ctrl  = '0;
        illegal = 1'b0;
        case (opcode)
            OP_ADD: e_ctrl.op2select = ~ir5;
            OP_AND: begin
                e_ctrl.alu_control = ALU_AND;
                e_ctrl.op2select   = ~ir5;
            end
            OP_NOT: e_ctrl.alu_control = ALU_NOT;
            OP_BR, OP_LD, OP_LDI, OP_LEA, OP_ST, OP_STI: begin
                e_ctrl.pcselect1 = PC1_OFF9;
                e_ctrl.pcselect2 = 1'b1;
            end
            OP_LDR, OP_STR: e_ctrl.pcselect1 = PC1_OFF6;
            OP_JMP: e_ctrl.pcselect1 = PC1_ZERO;
            default: illegal = 1'b1;
        endcase
    end

    assign w_ctrl = (opcode == OP_LD || opcode == OP_LDR || opcode == OP_LDI) ? W_MEM :
                    (opcode == OP_LEA) ? W_PCADDR : W_ALU;
    assign m_ctrl = (opcode == OP_LDI || opcode == OP_STI);
endmodule

// File: rtl/decode_stage.sv
// decode_stage: LC-3 pipeline decode stage registering IR/npc and the control words derived from them
//   clock          in  1   rising-edge clock
//   reset          in  1   asynchronous active-low reset
//   dout           in  DW  instruction word from instruction memory
//   npc_in         in  DW  next PC from fetch
//   enable_decode  in  1   capture and decode this cycle
//   IR, npc_out    out DW  registered instruction and npc
//   E_control      out 6   execute control word
//   W_control      out 2   writeback source select
//   Mem_control    out 1   indirect memory access (LDI/STI)
//   decode_valid   out 1   outputs hold an enabled decode
//   illegal_op     out 1   unsupported opcode; registered only when DECODE_ILLEGAL_OP_EN is defined
module decode_stage
    import lc3_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] dout,
    input  logic [DW-1:0] npc_in,
    input  logic          enable_decode,
    output logic [DW-1:0] IR,
    output logic [DW-1:0] npc_out,
    output logic [5:0]    E_control,
    output logic [1:0]    W_control,
    output logic          Mem_control,
    output logic          decode_valid,
    output logic          illegal_op
);
    e_ctrl_t    lut_e;
    logic [1:0] lut_w;
    logic       lut_m;
    logic       lut_illegal;

    decode_ctrl_lut u_lut (
        .opcode  (dout[15:12]),
        .ir5     (dout[5]),
        .e_ctrl  (lut_e),
        .w_ctrl  (lut_w),
        .m_ctrl  (lut_m),
        .illegal (lut_illegal)
    );

    // Controls are decoded from dout, not IR, so they land in the same edge as IR.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            IR           <= '0;
            npc_out      <= '0;
            E_control    <= '0;
            W_control    <= '0;
            Mem_control  <= 1'b0;
            decode_valid <= 1'b0;
        end else if (enable_decode) begin
            IR           <= dout;
            npc_out      <= npc_in;
            E_control    <= lut_e;
            W_control    <= lut_w;
            Mem_control  <= lut_m;
            decode_valid <= 1'b1;
        end
    end

`ifdef DECODE_ILLEGAL_OP_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            illegal_op <= 1'b0;
        else if (enable_decode)
            illegal_op <= lut_illegal;
    end
`else
    logic unused_illegal;
    assign unused_illegal = lut_illegal;
    assign illegal_op     = 1'b0;
`endif
endmodule
